// File: rtl/combat_resolver_if.sv
// combat_resolver_if: player-state inputs and stun/health/round outputs; master = player side, slave = resolver
interface combat_resolver_if;
  logic       p1_attack_active;
  logic [1:0] p1_attack_phase;
  logic       p1_moving_backward;
  logic [9:0] p1_x_pos;
  logic [9:0] p1_width;
  logic       p2_attack_active;
  logic [1:0] p2_attack_phase;
  logic       p2_moving_backward;
  logic [9:0] p2_x_pos;
  logic       p1_in_hitstun;
  logic       p1_in_blockstun;
  logic       p2_in_hitstun;
  logic       p2_in_blockstun;
  logic [7:0] p1_health;
  logic [7:0] p2_health;
  logic [1:0] hit_pulse;
  logic [1:0] block_pulse;
  logic       ko_out;
  logic [1:0] ko_winner;
  logic       round_reset_pulse;
  modport master (
    output p1_attack_active, p1_attack_phase, p1_moving_backward, p1_x_pos, p1_width,
           p2_attack_active, p2_attack_phase, p2_moving_backward, p2_x_pos,
    input  p1_in_hitstun, p1_in_blockstun, p2_in_hitstun, p2_in_blockstun,
           p1_health, p2_health, hit_pulse, block_pulse, ko_out, ko_winner, round_reset_pulse
  );
  modport slave (
    input  p1_attack_active, p1_attack_phase, p1_moving_backward, p1_x_pos, p1_width,
           p2_attack_active, p2_attack_phase, p2_moving_backward, p2_x_pos,
    output p1_in_hitstun, p1_in_blockstun, p2_in_hitstun, p2_in_blockstun,
           p1_health, p2_health, hit_pulse, block_pulse, ko_out, ko_winner, round_reset_pulse
  );
endinterface

// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hit/block arbiter; ports clk_game, reset, bus (stance/position in, stun/health/KO out)
module combat_resolver #(
  parameter logic [9:0] HIT_REACH        = 10'd16,
  parameter logic [7:0] HITSTUN_FRAMES   = 8'd20,
  parameter logic [7:0] BLOCKSTUN_FRAMES = 8'd12,
  parameter logic [7:0] HIT_DAMAGE       = 8'd10,
  parameter logic [7:0] HEALTH_MAX       = 8'd100,
  parameter logic [7:0] KO_HOLD_FRAMES   = 8'd120
) (
  input logic clk_game,
  input logic reset,
  combat_resolver_if.slave bus
);
  typedef enum logic [1:0] {FIGHT, KO, ROUND_RESET} state_t;
  state_t state, next_state;
  logic [7:0] hold;
  logic [7:0] hs [2];
  logic [7:0] bs [2];
  logic [7:0] health [2];
  logic [1:0] done, act, conn, blk, hit_on, blk_on;
  logic in_reach, rr_enter;
  always_comb begin
    act = {bus.p2_attack_active, bus.p1_attack_active};
    // compare in 12 bits so the clamped-at-zero gap needs no subtraction
    in_reach = {2'b0, bus.p2_x_pos} <= {2'b0, bus.p1_x_pos} + {2'b0, bus.p1_width} + {2'b0, HIT_REACH};
    conn = (state == FIGHT && in_reach) ? act & ~done : 2'b00;
    blk[0] = bus.p1_moving_backward && bus.p1_attack_phase == 2'b00 && hs[0] == 8'd0;
    blk[1] = bus.p2_moving_backward && bus.p2_attack_phase == 2'b00 && hs[1] == 8'd0;
    // index = defender; attacker is the other player
    hit_on = {conn[0] & ~blk[1], conn[1] & ~blk[0]};
    blk_on = {conn[0] & blk[1], conn[1] & blk[0]};
    next_state = state;
    case (state)
      FIGHT:   next_state = (health[0] == 8'd0 || health[1] == 8'd0) ? KO : FIGHT;
      KO:      next_state = (hold == KO_HOLD_FRAMES - 8'd1) ? ROUND_RESET : KO;
      default: next_state = FIGHT;
    endcase
    rr_enter = next_state == ROUND_RESET;
  end
  always_ff @(posedge clk_game)
    state <= reset ? FIGHT : next_state;
  for (genvar g = 0; g < 2; g++) begin : g_player
    always_ff @(posedge clk_game) begin
      if (reset || rr_enter) begin
        hs[g] <= 8'd0;
        bs[g] <= 8'd0;
        health[g] <= HEALTH_MAX;
      end else begin
        hs[g] <= hit_on[g] ? HITSTUN_FRAMES : (hs[g] != 8'd0 ? hs[g] - 8'd1 : 8'd0);
        bs[g] <= blk_on[g] ? BLOCKSTUN_FRAMES : hit_on[g] ? 8'd0 : (bs[g] != 8'd0 ? bs[g] - 8'd1 : 8'd0);
        health[g] <= hit_on[g] ? (health[g] > HIT_DAMAGE ? health[g] - HIT_DAMAGE : 8'd0) : health[g];
      end
    end
  end
  always_ff @(posedge clk_game) begin
    if (reset) begin
      done <= 2'b00;
      hold <= 8'd0;
      bus.hit_pulse <= 2'b00;
      bus.block_pulse <= 2'b00;
      bus.ko_out <= 1'b0;
      bus.ko_winner <= 2'b00;
      bus.round_reset_pulse <= 1'b0;
    end else begin
      done <= rr_enter ? 2'b00 : act & (done | conn);
      hold <= state == KO ? hold + 8'd1 : 8'd0;
      bus.hit_pulse <= {hit_on[0], hit_on[1]};
      bus.block_pulse <= {blk_on[0], blk_on[1]};
      bus.ko_out <= next_state == KO;
      bus.ko_winner <= next_state != KO ? 2'b00 : state == FIGHT ? {health[0] == 8'd0, health[1] == 8'd0} : bus.ko_winner;
      bus.round_reset_pulse <= rr_enter;
    end
  end
  assign bus.p1_in_hitstun = hs[0] != 8'd0;
  assign bus.p2_in_hitstun = hs[1] != 8'd0;
  assign bus.p1_in_blockstun = bs[0] != 8'd0;
  assign bus.p2_in_blockstun = bs[1] != 8'd0;
  assign bus.p1_health = health[0];
  assign bus.p2_health = health[1];
endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Per-frame hit/block arbiter between the two player_logic instances.
- Consumes each player's attack_active, attack_phase, position/width and moving_backward.
- Decides hits, blocks and trades; drives each player's in_hitstun/in_blockstun; owns both health counters and the round FSM (FIGHT -> KO -> ROUND_RESET).
- Sits in the game-tick domain alongside both player blocks.

Parameters:
- HIT_REACH, 10'd16: max gap in pixels between P1 right edge and P2 left edge at which an active attack connects.
- HITSTUN_FRAMES, 8'd20: cycles of hitstun per hit.
- BLOCKSTUN_FRAMES, 8'd12: cycles of blockstun per blocked attack.
- HIT_DAMAGE, 8'd10: health removed per clean hit.
- HEALTH_MAX, 8'd100: health after reset and at round start.
- KO_HOLD_FRAMES, 8'd120: cycles spent in KO before the round resets.

Ports:
- clk_game  in  1: game tick clock.
- reset  in  1: synchronous, active-high.
- p1_attack_active  in  1: P1 in ACTIVE phase.
- p1_attack_phase  in  2: P1 phase (00 idle, 01 startup, 10 active, 11 recovery).
- p1_moving_backward  in  1: P1 holding back.
- p1_x_pos  in  10: P1 left x.
- p1_width  in  10: P1 width.
- p2_attack_active  in  1: P2 in ACTIVE phase.
- p2_attack_phase  in  2: as P1.
- p2_moving_backward  in  1: P2 holding back.
- p2_x_pos  in  10: P2 left x. P2 is always right of P1.
- p1_in_hitstun  out  1: to P1 in_hitstun.
- p1_in_blockstun  out  1: to P1 in_blockstun.
- p2_in_hitstun  out  1: to P2 in_hitstun.
- p2_in_blockstun  out  1: to P2 in_blockstun.
- p1_health  out  8: P1 health.
- p2_health  out  8: P2 health.
- hit_pulse  out  2: one-cycle, bit0 = P1 landed a hit, bit1 = P2 landed a hit.
- block_pulse  out  2: one-cycle, bit0 = P1's attack was blocked, bit1 = P2's attack was blocked.
- ko_out  out  1: high in KO state.
- ko_winner  out  2: 01 P1 wins, 10 P2 wins, 11 double KO, 00 none.
- round_reset_pulse  out  1: one-cycle, drives the player blocks' round restart.

Behaviour:
- Clock and reset:
  - One clock, clk_game. reset is synchronous, active-high.
  - All outputs are registered.
- Reset values:
  - stun counters 0, so all stun outputs 0.
  - health = HEALTH_MAX.
  - pulses 0, ko_out 0, ko_winner 00.
  - state = FIGHT, hit_done flags 0.
- Gap:
  - gap = p2_x_pos - (p1_x_pos + p1_width), computed 11-bit.
  - Negative result clamps to 0.
  - in_reach = (gap <= HIT_REACH).
- Connect: Px connects in a cycle when state == FIGHT && px_attack_active && !px_hit_done && in_reach.
  - Set px_hit_done on connect.
  - Clear px_hit_done when px_attack_active is low, so each ACTIVE window yields at most one connect.
- Block: the defender blocks if all of the following hold:
  - defender moving_backward = 1;
  - defender attack_phase = 00;
  - defender hitstun counter = 0.
  Otherwise the connect is a hit.
- Hit on defender:
  - Defender hitstun counter <= HITSTUN_FRAMES; blockstun counter <= 0.
  - Defender health <= saturating (health - HIT_DAMAGE), floor 0.
  - hit_pulse bit for the attacker.
- Block on defender:
  - Defender blockstun counter <= BLOCKSTUN_FRAMES; no damage.
  - block_pulse bit for the attacker.
  - A block during existing blockstun reloads the counter.
- Stun timing:
  - Connect is detected in cycle N; the stun output is high from cycle N+1 for exactly the loaded number of cycles.
  - Each nonzero counter decrements by 1 per cycle; stun output = (counter != 0).
- Trade: both players connect in the same cycle.
  - Both are evaluated independently; both may take a hit and damage.
  - Defender attack_phase != 00 for both, so a trade is never a block.
- KO:
  - Any health reaching 0 in FIGHT moves to KO on the next cycle.
  - ko_winner is set from which health is 0 (11 if both).
  - In KO: no new connects, stun counters keep decrementing, hold timer counts KO_HOLD_FRAMES cycles.
- ROUND_RESET: one cycle.
  - round_reset_pulse = 1.
  - Health restored to HEALTH_MAX; stun counters, hit_done and ko cleared.
  - Next state FIGHT.
- reset in any state, including mid-stun or mid-KO, restores all reset values on the next edge.

Test Plan:
- P1 x=100, w=32, P2 x=140 (gap 8); P1 active 2 cycles, P2 idle, not backing -> hit_pulse=01 for 1 cycle; p2_health 100->90; p2_in_hitstun high exactly 20 cycles starting the cycle after detection; no second hit in the same window.
- Same geometry, P2 moving_backward=1, phase 00 -> block_pulse=01; p2_in_blockstun high 12 cycles; p2_health stays 100.
- Gap 17 (P2 x=149) with P1 active -> no pulses, no stun; gap exactly 16 -> hit; overlap (P2 x < P1 right edge) -> gap clamps to 0, hit.
- Both active in the same cycle at gap 0 -> hit_pulse=11; both health 90; both hitstun 20 cycles.
- P2 health 10, P1 lands a hit -> p2_health=0; ko_out=1, ko_winner=01 next cycle; further attacks ignored; after 120 cycles round_reset_pulse for 1 cycle, both health 100, state FIGHT.
- reset asserted while P2 hitstun counter=7 and in KO -> next cycle all stun outputs 0, health 100, ko_out 0, no round_reset_pulse.
